// File: rtl/neuron_pkg.sv
// Shared constants and types for the neuron datapath stages.
package neuron_pkg;

    localparam int unsigned Fp32W      = 32;
    localparam int unsigned SignBit    = 31;
    localparam int unsigned ExpMsb     = 30;
    localparam int unsigned ExpLsb     = 23;
    localparam int unsigned MantW      = 23;
    localparam logic [7:0]  ExpAllOnes = 8'hFF;

    localparam int unsigned SpikeIdW  = 16;
    localparam int unsigned SpikeCntW = 16;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCmp     = 2'd1,
        StFire    = 2'd2,
        StRefract = 2'd3
    } lif_state_e;

    function automatic logic fp32_is_nan(input logic [Fp32W-1:0] x);
        return (x[ExpMsb:ExpLsb] == ExpAllOnes) && (x[MantW-1:0] != '0);
    endfunction

endpackage

// File: rtl/fp32_ge_cmp.sv
// Combinational FP32 a >= b in sign-magnitude order; denormals compared exactly, +0 == -0.
module fp32_ge_cmp
    import neuron_pkg::*;
(
    input  logic [Fp32W-1:0] a_i,
    input  logic [Fp32W-1:0] b_i,
    output logic             ge_o,
    output logic             is_nan_o
);

    logic [Fp32W-2:0] a_mag;
    logic [Fp32W-2:0] b_mag;

    always_comb begin
        a_mag    = a_i[Fp32W-2:0];
        b_mag    = b_i[Fp32W-2:0];
        is_nan_o = fp32_is_nan(a_i) | fp32_is_nan(b_i);
        if (is_nan_o) begin
            ge_o = 1'b0;
        end else if ((a_mag == '0) && (b_mag == '0)) begin
            ge_o = 1'b1;
        end else if (a_i[SignBit] != b_i[SignBit]) begin
            ge_o = ~a_i[SignBit];
        end else if (!a_i[SignBit]) begin
            ge_o = (a_mag >= b_mag);
        end else begin
            // Both negative: larger magnitude is the smaller value.
            ge_o = (a_mag <= b_mag);
        end
    end

endmodule

// File: rtl/lif_spike_gen.sv
// Leaky-integrate-and-fire spike generator: threshold compare, spike token handoff,
// accumulator clear and refractory window.
module lif_spike_gen
    import neuron_pkg::*;
#(
    parameter logic [Fp32W-1:0]    Threshold     = 32'h40E00000,
    parameter int unsigned         RefractCycles = 4,
    parameter logic [SpikeIdW-1:0] NeuronId      = 16'h0000,
    parameter int unsigned         TsW           = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 acc_valid_i,
    output logic                 acc_ready_o,
    input  logic [Fp32W-1:0]     acc_value_i,
    input  logic                 acc_exception_i,
    output logic                 clear_acc_o,
    output logic                 spike_valid_o,
    input  logic                 spike_ready_i,
    output logic [SpikeIdW-1:0]  spike_id_o,
    output logic [TsW-1:0]       spike_time_o,
    output logic                 refractory_o,
    output logic [SpikeCntW-1:0] spike_count_o,
    output logic                 nan_err_o
);

    localparam int unsigned RcW = (RefractCycles > 1) ? $clog2(RefractCycles + 1) : 1;

    lif_state_e           state_q, state_d;
    logic [Fp32W-1:0]     v_q, v_d;
    logic                 exc_q, exc_d;
    logic                 ge_q, ge_d;
    logic                 nan_q, nan_d;
    logic                 cmp_ph_q, cmp_ph_d;
    logic                 clear_q, clear_d;
    logic [TsW-1:0]       time_q, time_d;
    logic [SpikeCntW-1:0] cnt_q, cnt_d;
    logic                 nan_err_q, nan_err_d;
    logic [RcW-1:0]       rc_q, rc_d;
    logic [TsW-1:0]       ts_q;
    logic                 cmp_ge, cmp_nan;
    logic                 accept;

    fp32_ge_cmp u_cmp (
        .a_i      (v_q),
        .b_i      (Threshold),
        .ge_o     (cmp_ge),
        .is_nan_o (cmp_nan)
    );

    assign acc_ready_o   = rst_ni & ((state_q == StIdle) | (state_q == StRefract));
    assign accept        = acc_valid_i & acc_ready_o;
    assign spike_valid_o = (state_q == StFire);
    assign clear_acc_o   = clear_q;
    assign refractory_o  = (state_q == StRefract);
    assign spike_id_o    = NeuronId;
    assign spike_time_o  = time_q;
    assign spike_count_o = cnt_q;
    assign nan_err_o     = nan_err_q;

    always_comb begin
        state_d   = state_q;
        v_d       = v_q;
        exc_d     = exc_q;
        ge_d      = ge_q;
        nan_d     = nan_q;
        cmp_ph_d  = 1'b0;
        clear_d   = 1'b0;
        time_d    = time_q;
        cnt_d     = cnt_q;
        nan_err_d = nan_err_q;
        rc_d      = rc_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    v_d     = acc_value_i;
                    exc_d   = acc_exception_i;
                    state_d = StCmp;
                end
            end
            StCmp: begin
                // First half registers the compare, second half acts on it.
                if (!cmp_ph_q) begin
                    ge_d     = cmp_ge;
                    nan_d    = cmp_nan | exc_q;
                    cmp_ph_d = 1'b1;
                end else if (nan_q) begin
                    nan_err_d = 1'b1;
                    state_d   = StIdle;
                end else if (ge_q) begin
                    time_d  = ts_q;
                    clear_d = 1'b1;
                    state_d = StFire;
                end else begin
                    state_d = StIdle;
                end
            end
            StFire: begin
                if (spike_ready_i) begin
                    cnt_d = cnt_q + SpikeCntW'(1);
                    if (RefractCycles == 0) begin
                        state_d = StIdle;
                    end else begin
                        rc_d    = RcW'(RefractCycles);
                        state_d = StRefract;
                    end
                end
            end
            StRefract: begin
                // Samples accepted here are dropped on the floor.
                if (rc_q <= RcW'(1)) begin
                    state_d = StIdle;
                end else begin
                    rc_d = rc_q - RcW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            v_q       <= '0;
            exc_q     <= 1'b0;
            ge_q      <= 1'b0;
            nan_q     <= 1'b0;
            cmp_ph_q  <= 1'b0;
            clear_q   <= 1'b0;
            time_q    <= '0;
            cnt_q     <= '0;
            nan_err_q <= 1'b0;
            rc_q      <= '0;
            ts_q      <= '0;
        end else begin
            state_q   <= state_d;
            v_q       <= v_d;
            exc_q     <= exc_d;
            ge_q      <= ge_d;
            nan_q     <= nan_d;
            cmp_ph_q  <= cmp_ph_d;
            clear_q   <= clear_d;
            time_q    <= time_d;
            cnt_q     <= cnt_d;
            nan_err_q <= nan_err_d;
            rc_q      <= rc_d;
            ts_q      <= ts_q + TsW'(1);
        end
    end

endmodule

// File: tb/tb_lif_spike_gen.sv
// Directed bench: DUT 0 uses threshold 7.0 with a 3-cycle refractory window,
// DUT 1 uses threshold 0.0 with no refractory window.
module tb_lif_spike_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        acc_valid   [2];
    logic        acc_exc     [2];
    logic        spike_ready [2];
    logic [31:0] acc_value   [2];
    logic        acc_ready   [2];
    logic        clear_acc   [2];
    logic        spike_valid [2];
    logic        refractory  [2];
    logic        nan_err     [2];
    logic [15:0] spike_id    [2];
    logic [15:0] spike_time  [2];
    logic [15:0] spike_count [2];
    logic [15:0] ts_m;
    logic [15:0] t_exp;
    int n_chk = 0;
    int n_bad = 0;

    lif_spike_gen #(
        .Threshold     (32'h40E00000),
        .RefractCycles (3),
        .NeuronId      (16'h00A5),
        .TsW           (16)
    ) u_dut0 (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .acc_valid_i     (acc_valid[0]),
        .acc_ready_o     (acc_ready[0]),
        .acc_value_i     (acc_value[0]),
        .acc_exception_i (acc_exc[0]),
        .clear_acc_o     (clear_acc[0]),
        .spike_valid_o   (spike_valid[0]),
        .spike_ready_i   (spike_ready[0]),
        .spike_id_o      (spike_id[0]),
        .spike_time_o    (spike_time[0]),
        .refractory_o    (refractory[0]),
        .spike_count_o   (spike_count[0]),
        .nan_err_o       (nan_err[0])
    );

    lif_spike_gen #(
        .Threshold     (32'h00000000),
        .RefractCycles (0),
        .NeuronId      (16'h0003),
        .TsW           (16)
    ) u_dut1 (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .acc_valid_i     (acc_valid[1]),
        .acc_ready_o     (acc_ready[1]),
        .acc_value_i     (acc_value[1]),
        .acc_exception_i (acc_exc[1]),
        .clear_acc_o     (clear_acc[1]),
        .spike_valid_o   (spike_valid[1]),
        .spike_ready_i   (spike_ready[1]),
        .spike_id_o      (spike_id[1]),
        .spike_time_o    (spike_time[1]),
        .refractory_o    (refractory[1]),
        .spike_count_o   (spike_count[1]),
        .nan_err_o       (nan_err[1])
    );

    // Reference free-running timestamp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_m <= '0;
        else        ts_m <= ts_m + 16'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input int d, input string tag);
        chk({tag, "_rdy"}, 32'(acc_ready[d]), 32'd0);
        chk({tag, "_vld"}, 32'(spike_valid[d]), 32'd0);
        chk({tag, "_clr"}, 32'(clear_acc[d]), 32'd0);
        chk({tag, "_ref"}, 32'(refractory[d]), 32'd0);
        chk({tag, "_nan"}, 32'(nan_err[d]), 32'd0);
        chk({tag, "_cnt"}, 32'(spike_count[d]), 32'd0);
        chk({tag, "_time"}, 32'(spike_time[d]), 32'd0);
    endtask

    // Offer one sample from IDLE and check the outcome two edges after accept.
    task automatic send(input int d, input logic [31:0] val, input logic exc,
                        input logic fire, input string tag);
        acc_value[d] = val;
        acc_exc[d]   = exc;
        acc_valid[d] = 1'b1;
        chk({tag, "_rdy"}, 32'(acc_ready[d]), 32'd1);
        @(posedge clk); #1;
        acc_valid[d] = 1'b0;
        acc_exc[d]   = 1'b0;
        chk({tag, "_cmp_rdy"}, 32'(acc_ready[d]), 32'd0);
        chk({tag, "_early"}, 32'(spike_valid[d]), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_early2"}, 32'(spike_valid[d] | clear_acc[d]), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_vld"}, 32'(spike_valid[d]), 32'(fire));
        chk({tag, "_clr"}, 32'(clear_acc[d]), 32'(fire));
        if (fire) begin
            t_exp = ts_m - 16'd1;
            chk({tag, "_time"}, 32'(spike_time[d]), 32'(t_exp));
        end else begin
            chk({tag, "_idle"}, 32'(acc_ready[d]), 32'd1);
        end
    endtask

    // One edge for the handshake (spike_ready already high), then walk the window.
    task automatic hs(input int d, input int cnt_exp, input int refr, input string tag);
        @(posedge clk); #1;
        chk({tag, "_hs_vld"}, 32'(spike_valid[d]), 32'd0);
        chk({tag, "_hs_clr"}, 32'(clear_acc[d]), 32'd0);
        chk({tag, "_hs_cnt"}, 32'(spike_count[d]), 32'(cnt_exp));
        for (int k = 0; k < refr; k++) begin
            chk({tag, "_ref_on"}, 32'(refractory[d]), 32'd1);
            @(posedge clk); #1;
        end
        chk({tag, "_ref_off"}, 32'(refractory[d]), 32'd0);
        chk({tag, "_ref_rdy"}, 32'(acc_ready[d]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            acc_valid[d]   = 1'b0;
            acc_exc[d]     = 1'b0;
            acc_value[d]   = '0;
            spike_ready[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk_reset(0, "rst0");
        chk_reset(1, "rst1");
        chk("id0", 32'(spike_id[0]), 32'h00A5);
        chk("id1", 32'(spike_id[1]), 32'h0003);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Below threshold, above, equal.
        send(0, 32'h3F000000, 1'b0, 1'b0, "half");
        spike_ready[0] = 1'b1;
        send(0, 32'h40F00000, 1'b0, 1'b1, "f7p5");
        chk("f7p5_id", 32'(spike_id[0]), 32'h00A5);
        hs(0, 1, 3, "f7p5");
        send(0, 32'h40E00000, 1'b0, 1'b1, "feq");
        hs(0, 2, 3, "feq");

        // Negative values and invalid samples.
        send(0, 32'hC0000000, 1'b0, 1'b0, "neg2");
        send(0, 32'hFF800000, 1'b0, 1'b0, "ninf");
        chk("nan_clean", 32'(nan_err[0]), 32'd0);
        send(0, 32'h7FC00000, 1'b0, 1'b0, "nan");
        chk("nan_set", 32'(nan_err[0]), 32'd1);
        send(0, 32'h3F800000, 1'b1, 1'b0, "exc");
        send(0, 32'h3F000000, 1'b0, 1'b0, "after");
        chk("nan_sticky", 32'(nan_err[0]), 32'd1);
        chk("cnt_still2", 32'(spike_count[0]), 32'd2);

        // Backpressure: token held five cycles, clear_acc only once.
        spike_ready[0] = 1'b0;
        send(0, 32'h40F00000, 1'b0, 1'b1, "bp");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_vld", 32'(spike_valid[0]), 32'd1);
            chk("bp_clr", 32'(clear_acc[0]), 32'd0);
            chk("bp_time", 32'(spike_time[0]), 32'(t_exp));
            chk("bp_cnt", 32'(spike_count[0]), 32'd2);
        end
        spike_ready[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_hs_vld", 32'(spike_valid[0]), 32'd0);
        chk("bp_hs_cnt", 32'(spike_count[0]), 32'd3);
        chk("bp_ref1", 32'(refractory[0]), 32'd1);

        // Sample offered inside the window is swallowed.
        acc_value[0] = 32'h40F00000;
        acc_valid[0] = 1'b1;
        chk("drop_rdy", 32'(acc_ready[0]), 32'd1);
        @(posedge clk); #1;
        acc_valid[0] = 1'b0;
        chk("bp_ref2", 32'(refractory[0]), 32'd1);
        @(posedge clk); #1;
        chk("bp_ref3", 32'(refractory[0]), 32'd1);
        @(posedge clk); #1;
        chk("bp_ref_end", 32'(refractory[0]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("drop_novld", 32'(spike_valid[0]), 32'd0);
        end
        chk("drop_cnt", 32'(spike_count[0]), 32'd3);

        // Reset in the middle of the refractory window.
        send(0, 32'h40F00000, 1'b0, 1'b1, "pre_rst");
        @(posedge clk); #1;
        chk("pre_rst_cnt", 32'(spike_count[0]), 32'd4);
        chk("pre_rst_ref", 32'(refractory[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset(0, "mid_rst");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        send(0, 32'h40F00000, 1'b0, 1'b1, "post_rst");
        hs(0, 1, 3, "post_rst");

        // Zero threshold, no refractory window.
        spike_ready[1] = 1'b1;
        send(1, 32'h80000000, 1'b0, 1'b1, "negz");
        hs(1, 1, 0, "negz");
        send(1, 32'h7F800000, 1'b0, 1'b1, "pinf");
        hs(1, 2, 0, "pinf");
        send(1, 32'hFF800000, 1'b0, 1'b0, "z_ninf");
        send(1, 32'h00000001, 1'b0, 1'b1, "pden");
        hs(1, 3, 0, "pden");
        send(1, 32'h80000001, 1'b0, 1'b0, "nden");
        chk("z_nan", 32'(nan_err[1]), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
